// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - instruction memory req/ack bus between fetch and imem
interface fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - MIPS IF stage: owns the PC, fetches over req/ack, loads IF/ID
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 reset,
    fetch_stage_if.master        imem,
    input  logic                 stall,
    input  logic                 redirect,
    input  logic [31:0]          redirect_pc,
    output logic                 if_id_valid,
    output logic [31:0]          if_id_instr,
    output logic [31:0]          if_id_pc,
    output logic [31:0]          if_id_pcplus4
);

    typedef enum logic {S_FETCH, S_HOLD} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        discard_q, discard_d;
    logic [31:0] target_q, target_d;
    logic [31:0] buf_instr_q, buf_instr_d;
    logic [31:0] buf_pc_q, buf_pc_d;
    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] idpc_q, idpc_d;
    logic [31:0] idpc4_q, idpc4_d;

    logic [31:0] redir_pc;
    logic        slot_free;
    logic        loaded;

    assign redir_pc       = redirect_pc & ~32'h3;
    assign slot_free      = !valid_q || !stall;
    assign imem.imem_req  = (state_q == S_FETCH) && !reset;
    assign imem.imem_addr = pc_q;

    assign if_id_valid    = valid_q;
    assign if_id_instr    = instr_q;
    assign if_id_pc       = idpc_q;
    assign if_id_pcplus4  = idpc4_q;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        discard_d   = discard_q;
        target_d    = target_q;
        buf_instr_d = buf_instr_q;
        buf_pc_d    = buf_pc_q;
        valid_d     = valid_q;
        instr_d     = instr_q;
        idpc_d      = idpc_q;
        idpc4_d     = idpc4_q;
        loaded      = 1'b0;

        case (state_q)
            S_FETCH: begin
                if (imem.imem_ack) begin
                    if (redirect) begin
                        pc_d      = redir_pc;
                        discard_d = 1'b0;
                    end else if (discard_q) begin
                        pc_d      = target_q;
                        discard_d = 1'b0;
                    end else if (slot_free) begin
                        loaded  = 1'b1;
                        valid_d = 1'b1;
                        instr_d = imem.imem_rdata;
                        idpc_d  = pc_q;
                        idpc4_d = pc_q + 32'd4;
                        pc_d    = pc_q + 32'd4;
                    end else begin
                        buf_instr_d = imem.imem_rdata;
                        buf_pc_d    = pc_q;
                        pc_d        = pc_q + 32'd4;
                        state_d     = S_HOLD;
                    end
                end else if (redirect) begin
                    // Request stays in flight with its address; its data is dropped on ack.
                    discard_d = 1'b1;
                    target_d  = redir_pc;
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    pc_d    = redir_pc;
                    state_d = S_FETCH;
                end else if (!stall) begin
                    loaded  = 1'b1;
                    valid_d = 1'b1;
                    instr_d = buf_instr_q;
                    idpc_d  = buf_pc_q;
                    idpc4_d = buf_pc_q + 32'd4;
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_FETCH;
        endcase

        // Redirect beats stall; an unstalled slot with nothing new drains to a bubble.
        if (redirect || (!loaded && !stall)) begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_FETCH;
            pc_q        <= RESET_PC;
            discard_q   <= 1'b0;
            target_q    <= 32'h0;
            buf_instr_q <= 32'h0;
            buf_pc_q    <= 32'h0;
            valid_q     <= 1'b0;
            instr_q     <= NOP_INSTR;
            idpc_q      <= 32'h0;
            idpc4_q     <= 32'h0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            discard_q   <= discard_d;
            target_q    <= target_d;
            buf_instr_q <= buf_instr_d;
            buf_pc_q    <= buf_pc_d;
            valid_q     <= valid_d;
            instr_q     <= instr_d;
            idpc_q      <= idpc_d;
            idpc4_q     <= idpc4_d;
        end
    end

endmodule
